pt2272_word_assembler: RTL and testbench
========================================

// Module: pt2272_word_assembler
// PURPOSE
//  Downstream stage of the PT2272 pulse-width symbol detector. Collects detected symbols (0/1/F/SYNC)
//  into 12-symbol code words framed by SYNC and checks the 8 address trits against addr_i.
//  Requires REPEAT consecutive identical valid words, then latches the 4 data bits on D and
//  pulses dv. Runs in the 12 kHz osc_clk domain produced by the decoder's clock divider.
// PARAMETERS
//  N_ADDR   8     address trits per word (symbols 0..N_ADDR-1)
//  N_DATA   4     data bits per word (symbols N_ADDR..N_ADDR+N_DATA-1)
//  REPEAT   2     consecutive identical valid words required before dv
//  TIMEOUT  1024  osc_clk cycles without sym_valid that abort reception
// PORTS
//  osc_clk    in   1         12 kHz clock; all logic rising-edge
//  reset      in   1         asynchronous, active-high
//  sym_valid  in   1         one-cycle strobe: sym_code holds a new symbol
//  sym_code   in   2         00=bit0, 11=bit1, 10=F (float), 01=SYNC
//  addr_i     in   2*N_ADDR  expected address; trit k = addr_i[2k+1:2k], same code as sym_code
//  D          out  N_DATA    latched data; D[j] = data symbol j (1 for 11, 0 for 00)
//  dv         out  1         one-cycle pulse: new D latched
//  vt         out  1         valid-transmission level: high while accepted words keep arriving
//  word_err   out  1         one-cycle pulse: framing or content error on a word
// BEHAVIOUR
//  Reset: D=0, dv=0, vt=0, word_err=0, sym_cnt=0, match_cnt=0, prev_data=0, idle_cnt=0, state=HUNT.
//  Symbol order on air: addr trit 0 first, then data bit 0..N_DATA-1, then SYNC.
//  States (all transitions happen only on cycles with sym_valid=1, except timeout):
//   HUNT:        SYNC -> COLLECT, sym_cnt=0; other symbols are ignored (no word_err).
//   COLLECT:     non-SYNC -> store symbol at index sym_cnt, sym_cnt++; if sym_cnt reaches
//                N_ADDR+N_DATA -> EXPECT_SYNC. SYNC here (early) -> word_err, match_cnt=0, vt=0,
//                stay in COLLECT with sym_cnt=0 (this SYNC frames the next word).
//   EXPECT_SYNC: SYNC -> evaluate the word, then go to COLLECT with sym_cnt=0.
//                Non-SYNC -> word_err, match_cnt=0, vt=0, go to HUNT.
//  Word evaluation (in the cycle the closing SYNC is accepted):
//   valid = all address trits equal addr_i AND every data symbol is 00 or 11 (F/SYNC invalid).
//   Invalid word -> word_err, match_cnt=0, vt=0.
//   Valid, data==prev_data and match_cnt>0 -> match_cnt=min(match_cnt+1, REPEAT).
//   Valid otherwise -> prev_data=data, match_cnt=1; if vt=1 then vt=0 (data changed mid-burst).
//   When match_cnt goes from REPEAT-1 to REPEAT: D<=data, dv=1 for one cycle, vt=1.
//   Further identical words at match_cnt=REPEAT give no new dv; vt stays 1.
//   REPEAT=1: every first valid word after a clear/change fires dv.
//  Latency: dv/D/vt/word_err are registered; they update on the osc_clk edge that samples the
//   closing SYNC's sym_valid, and are visible one cycle later.
//  Timeout: idle_cnt counts cycles since the last sym_valid (cleared by sym_valid). Reaching
//   TIMEOUT-1 -> state=HUNT, match_cnt=0, vt=0, idle_cnt holds. No word_err. D keeps its value.
//  Boundaries: sym_valid on the same cycle as timeout -> the symbol wins (it clears idle_cnt and
//   is processed normally). sym_cnt never exceeds N_ADDR+N_DATA. match_cnt saturates at REPEAT.
//  Reset mid-word: everything returns to reset values immediately; the partial word is lost.
//  addr_i is sampled only at evaluation; changing it mid-word is legal.
// STRUCTURE
//  Package pt2272_pkg: sym_t enum {SYM_0=2'b00, SYM_SYNC=2'b01, SYM_F=2'b10, SYM_1=2'b11}
//   (shared with the symbol detector); asm_state_t {HUNT, COLLECT, EXPECT_SYNC};
//   localparams N_WORD = N_ADDR+N_DATA and the widths of sym_cnt/match_cnt/idle_cnt.
//  Sub-module pt2272_idle_timer: TIMEOUT counter with clear input and a sticky "expired" output.
//  Symbol store: 2*N_WORD-bit register written by index (no shift needed); evaluation combinational.
// TESTING  (addr_i=16'hAAAA = all F unless stated; "word" = 12 symbols + SYNC)
//  1. SYNC, then 2x word {F x8, 1,0,1,1}+SYNC -> single dv pulse after 2nd SYNC, D=4'b1101, vt=1, no word_err.
//  2. Word with addr trit 3 = 0, sent 3x -> word_err pulse after each closing SYNC, dv never asserts, vt=0.
//  3. Words with D=4'b0011, then 4'b0101, then 4'b0101 -> dv once (after 3rd), D=4'b0101; D stays 0 earlier.
//  4. SYNC after 7 symbols, then 2 complete valid words -> word_err at the early SYNC, then dv after 2nd word.
//  5. Valid burst (vt=1), then no sym_valid for TIMEOUT cycles -> vt=0, state HUNT, D unchanged; repeating
//     the same 2 words -> dv again.
//  6. Assert reset after 5 symbols of the 2nd word -> all outputs 0 next cycle; subsequent 2 valid words -> dv.

Source files
------------

// File: rtl/pt2272_pkg.sv
// PT2272 shared types: symbol codes and word assembler state.
// Default geometry and counter widths used by the assembler.
package pt2272_pkg;

    typedef enum logic [1:0] {
        SYM_0    = 2'b00,
        SYM_SYNC = 2'b01,
        SYM_F    = 2'b10,
        SYM_1    = 2'b11
    } sym_t;

    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        EXPECT_SYNC
    } asm_state_t;

    localparam int N_ADDR_DFLT  = 8;
    localparam int N_DATA_DFLT  = 4;
    localparam int REPEAT_DFLT  = 2;
    localparam int TIMEOUT_DFLT = 1024;

    localparam int N_WORD      = N_ADDR_DFLT + N_DATA_DFLT;
    localparam int SYM_CNT_W   = $clog2(N_WORD + 1);
    localparam int MATCH_CNT_W = $clog2(REPEAT_DFLT + 1);
    localparam int IDLE_CNT_W  = $clog2(TIMEOUT_DFLT);

endpackage

// File: rtl/pt2272_idle_timer.sv
// Idle timer: counts cycles since the last symbol strobe.
// Holds at TIMEOUT-1, so expired stays high until cleared.
module pt2272_idle_timer
    import pt2272_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DFLT,
    localparam int W = $clog2(TIMEOUT)
) (
    input  logic osc_clk,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] idle_cnt_q;
    logic [W-1:0] idle_cnt_d;

    // next count: clear on strobe, saturate at the last value
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (clear) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != LAST) begin
            idle_cnt_d = idle_cnt_q + W'(1);
        end
    end

    // counter register
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign expired = (idle_cnt_q == LAST);

endmodule

// File: rtl/pt2272_word_assembler.sv
// PT2272 word assembler: frames symbols into words, checks
// address, and latches data after REPEAT identical words.
module pt2272_word_assembler
    import pt2272_pkg::*;
#(
    parameter int N_ADDR  = N_ADDR_DFLT,
    parameter int N_DATA  = N_DATA_DFLT,
    parameter int REPEAT  = REPEAT_DFLT,
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic                  osc_clk,
    input  logic                  reset,
    input  logic                  sym_valid,
    input  logic [1:0]            sym_code,
    input  logic [2*N_ADDR-1:0]   addr_i,
    output logic [N_DATA-1:0]     D,
    output logic                  dv,
    output logic                  vt,
    output logic                  word_err
);

    localparam int NW  = N_ADDR + N_DATA;
    localparam int SCW = $clog2(NW + 1);
    localparam int MCW = $clog2(REPEAT + 1);

    localparam logic [SCW-1:0] LAST_IDX  = SCW'(NW - 1);
    localparam logic [MCW-1:0] MATCH_MAX = MCW'(REPEAT);

    asm_state_t        state_q, state_d;
    logic [SCW-1:0]    sym_cnt_q, sym_cnt_d;
    logic [2*NW-1:0]   store_q, store_d;
    logic [MCW-1:0]    match_cnt_q, match_cnt_d;
    logic [N_DATA-1:0] prev_data_q, prev_data_d;
    logic [N_DATA-1:0] d_q, d_d;
    logic              dv_q, dv_d;
    logic              vt_q, vt_d;
    logic              word_err_q, word_err_d;

    logic              expired;
    logic [N_DATA-1:0] word_data;
    logic              data_ok;
    logic              addr_ok;
    logic              fresh;
    sym_t              sym;

    pt2272_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .osc_clk (osc_clk),
        .reset   (reset),
        .clear   (sym_valid),
        .expired (expired)
    );

    assign sym = sym_t'(sym_code);

    // decode the stored word: data bits, data legality, address match
    always_comb begin
        word_data = '0;
        data_ok   = 1'b1;
        for (int j = 0; j < N_DATA; j++) begin
            word_data[j] = store_q[2*(N_ADDR+j)+1];
            if (store_q[2*(N_ADDR+j)+1] != store_q[2*(N_ADDR+j)]) begin
                data_ok = 1'b0;
            end
        end
        addr_ok = (store_q[2*N_ADDR-1:0] == addr_i);
    end

    // framing FSM, symbol store and repeat matching
    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        store_d     = store_q;
        match_cnt_d = match_cnt_q;
        prev_data_d = prev_data_q;
        d_d         = d_q;
        dv_d        = 1'b0;
        vt_d        = vt_q;
        word_err_d  = 1'b0;
        fresh       = 1'b0;
        if (sym_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (sym == SYM_SYNC) begin
                        state_d   = COLLECT;
                        sym_cnt_d = '0;
                    end
                end
                COLLECT: begin
                    if (sym == SYM_SYNC) begin
                        word_err_d  = 1'b1;
                        match_cnt_d = '0;
                        vt_d        = 1'b0;
                        sym_cnt_d   = '0;
                    end else begin
                        for (int k = 0; k < NW; k++) begin
                            if (int'(sym_cnt_q) == k) begin
                                store_d[2*k +: 2] = sym_code;
                            end
                        end
                        sym_cnt_d = sym_cnt_q + SCW'(1);
                        if (sym_cnt_q == LAST_IDX) begin
                            state_d = EXPECT_SYNC;
                        end
                    end
                end
                EXPECT_SYNC: begin
                    if (sym == SYM_SYNC) begin
                        state_d   = COLLECT;
                        sym_cnt_d = '0;
                        if (!(addr_ok && data_ok)) begin
                            word_err_d  = 1'b1;
                            match_cnt_d = '0;
                            vt_d        = 1'b0;
                        end else begin
                            if (word_data == prev_data_q &&
                                match_cnt_q != '0) begin
                                if (match_cnt_q != MATCH_MAX) begin
                                    match_cnt_d = match_cnt_q + MCW'(1);
                                end
                            end else begin
                                fresh       = 1'b1;
                                prev_data_d = word_data;
                                match_cnt_d = MCW'(1);
                                vt_d        = 1'b0;
                            end
                            if (match_cnt_d == MATCH_MAX &&
                                (fresh || match_cnt_q != MATCH_MAX)) begin
                                d_d  = word_data;
                                dv_d = 1'b1;
                                vt_d = 1'b1;
                            end
                        end
                    end else begin
                        word_err_d  = 1'b1;
                        match_cnt_d = '0;
                        vt_d        = 1'b0;
                        state_d     = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (expired) begin
            state_d     = HUNT;
            match_cnt_d = '0;
            vt_d        = 1'b0;
        end
    end

    // state and output registers
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            sym_cnt_q   <= '0;
            store_q     <= '0;
            match_cnt_q <= '0;
            prev_data_q <= '0;
            d_q         <= '0;
            dv_q        <= 1'b0;
            vt_q        <= 1'b0;
            word_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            store_q     <= store_d;
            match_cnt_q <= match_cnt_d;
            prev_data_q <= prev_data_d;
            d_q         <= d_d;
            dv_q        <= dv_d;
            vt_q        <= vt_d;
            word_err_q  <= word_err_d;
        end
    end

    assign D        = d_q;
    assign dv       = dv_q;
    assign vt       = vt_q;
    assign word_err = word_err_q;

endmodule

// File: tb/tb_pt2272_word_assembler.sv
// Directed bench for the PT2272 word assembler.
// Pulse outputs are counted on the falling edge.
module tb_pt2272_word_assembler;

    logic        osc_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sym_valid = 1'b0;
    logic [1:0]  sym_code = 2'b00;
    logic [15:0] addr_i = 16'hAAAA;
    logic [3:0]  D;
    logic        dv;
    logic        vt;
    logic        word_err;

    int total = 0;
    int bad = 0;
    int dv_seen = 0;
    int err_seen = 0;
    int dv_base;
    int err_base;

    pt2272_word_assembler dut (
        .osc_clk   (osc_clk),
        .reset     (reset),
        .sym_valid (sym_valid),
        .sym_code  (sym_code),
        .addr_i    (addr_i),
        .D         (D),
        .dv        (dv),
        .vt        (vt),
        .word_err  (word_err)
    );

    always #5 osc_clk = ~osc_clk;

    // count output pulses
    always @(negedge osc_clk) begin
        if (!reset && dv) dv_seen++;
        if (!reset && word_err) err_seen++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mk(input logic [15:0] a,
                                       input logic [3:0] d);
        logic [23:0] w;
        w[15:0] = a;
        for (int j = 0; j < 4; j++) begin
            w[16+2*j +: 2] = d[j] ? 2'b11 : 2'b00;
        end
        return w;
    endfunction

    task automatic send_sym(input logic [1:0] c);
        @(negedge osc_clk);
        sym_valid = 1'b1;
        sym_code  = c;
        @(negedge osc_clk);
        sym_valid = 1'b0;
        @(negedge osc_clk);
    endtask

    task automatic send_part(input logic [23:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            send_sym(w[2*k +: 2]);
        end
    endtask

    task automatic send_word(input logic [15:0] a, input logic [3:0] d);
        send_part(mk(a, d), 12);
        send_sym(2'b01);
    endtask

    task automatic do_reset();
        @(negedge osc_clk);
        reset = 1'b1;
        @(negedge osc_clk);
        reset = 1'b0;
        @(negedge osc_clk);
    endtask

    task automatic mark();
        dv_base  = dv_seen;
        err_base = err_seen;
    endtask

    initial begin
        repeat (3) @(negedge osc_clk);
        reset = 1'b0;
        @(negedge osc_clk);
        check("rst_D", 32'(D), 32'h0);
        check("rst_dv", 32'(dv), 32'h0);
        check("rst_vt", 32'(vt), 32'h0);
        check("rst_err", 32'(word_err), 32'h0);

        // 1: two identical words
        mark();
        send_sym(2'b01);
        send_word(16'hAAAA, 4'b1101);
        check("t1_dv_first", 32'(dv_seen - dv_base), 32'd0);
        check("t1_vt_first", 32'(vt), 32'h0);
        send_word(16'hAAAA, 4'b1101);
        check("t1_dv", 32'(dv_seen - dv_base), 32'd1);
        check("t1_D", 32'(D), 32'hD);
        check("t1_vt", 32'(vt), 32'h1);
        check("t1_err", 32'(err_seen - err_base), 32'd0);
        send_word(16'hAAAA, 4'b1101);
        check("t1_dv_sat", 32'(dv_seen - dv_base), 32'd1);
        check("t1_vt_sat", 32'(vt), 32'h1);

        // 2: wrong address trit 3
        do_reset();
        mark();
        send_sym(2'b01);
        for (int r = 1; r <= 3; r++) begin
            send_word(16'hAA2A, 4'b1101);
            check("t2_err", 32'(err_seen - err_base), 32'(r));
        end
        check("t2_dv", 32'(dv_seen - dv_base), 32'd0);
        check("t2_vt", 32'(vt), 32'h0);

        // 3: data changes before settling
        do_reset();
        mark();
        send_sym(2'b01);
        send_word(16'hAAAA, 4'b0011);
        check("t3_D1", 32'(D), 32'h0);
        send_word(16'hAAAA, 4'b0101);
        check("t3_D2", 32'(D), 32'h0);
        check("t3_dv2", 32'(dv_seen - dv_base), 32'd0);
        send_word(16'hAAAA, 4'b0101);
        check("t3_dv", 32'(dv_seen - dv_base), 32'd1);
        check("t3_D", 32'(D), 32'h5);

        // 4: early SYNC after 7 symbols
        do_reset();
        mark();
        send_sym(2'b01);
        send_part(mk(16'hAAAA, 4'b1010), 7);
        send_sym(2'b01);
        check("t4_err", 32'(err_seen - err_base), 32'd1);
        send_word(16'hAAAA, 4'b1010);
        send_word(16'hAAAA, 4'b1010);
        check("t4_dv", 32'(dv_seen - dv_base), 32'd1);
        check("t4_D", 32'(D), 32'hA);
        check("t4_vt", 32'(vt), 32'h1);

        // 5: timeout drops vt, keeps D
        mark();
        repeat (1100) @(negedge osc_clk);
        check("t5_vt", 32'(vt), 32'h0);
        check("t5_D", 32'(D), 32'hA);
        check("t5_err", 32'(err_seen - err_base), 32'd0);
        send_part(mk(16'hAAAA, 4'b1010), 12);
        check("t5_hunt_err", 32'(err_seen - err_base), 32'd0);
        send_sym(2'b01);
        send_word(16'hAAAA, 4'b1010);
        send_word(16'hAAAA, 4'b1010);
        check("t5_dv", 32'(dv_seen - dv_base), 32'd1);
        check("t5_vt2", 32'(vt), 32'h1);

        // 6: reset in the middle of a word
        send_word(16'hAAAA, 4'b0110);
        check("t6_vt_chg", 32'(vt), 32'h0);
        send_part(mk(16'hAAAA, 4'b0110), 5);
        reset = 1'b1;
        #1;
        check("t6_rst_D", 32'(D), 32'h0);
        check("t6_rst_vt", 32'(vt), 32'h0);
        check("t6_rst_dv", 32'(dv), 32'h0);
        check("t6_rst_err", 32'(word_err), 32'h0);
        @(negedge osc_clk);
        reset = 1'b0;
        mark();
        send_sym(2'b01);
        send_word(16'hAAAA, 4'b0110);
        send_word(16'hAAAA, 4'b0110);
        check("t6_dv", 32'(dv_seen - dv_base), 32'd1);
        check("t6_D", 32'(D), 32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
